// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 active-low hex keypad one column at a time,
// debounces press and release, and emits one pulse per accepted key. The last
// four keys are kept as a nibble history in o_data (newest in [3:0]).
module hex_keypad_scanner #(
  parameter int SCAN_WIDTH      = 14,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_rows,
  input  logic        i_clear,
  output logic [3:0]  o_cols,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic [15:0] o_data
);

  localparam int                     DB_WIDTH = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_WIDTH-1:0]    DB_LAST  = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_WIDTH-1:0]  DIV_LAST = {SCAN_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Hex code printed on the key at (row, col).
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // {valid, index}: valid only when exactly one row is pulled low.
  function automatic logic [2:0] single_low(input logic [3:0] rows);
    logic [2:0] hit;
    case (rows)
      4'b1110: hit = {1'b1, 2'd0};
      4'b1101: hit = {1'b1, 2'd1};
      4'b1011: hit = {1'b1, 2'd2};
      4'b0111: hit = {1'b1, 2'd3};
      default: hit = {1'b0, 2'd0};
    endcase
    return hit;
  endfunction

  // Active-low one-cold pattern selecting a single line.
  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  logic [3:0]            rows_meta_r;
  logic [3:0]            rows_sync_r;
  logic [3:0]            rows_s;
  state_t                state_r,   state_s;
  logic [SCAN_WIDTH-1:0] div_r,     div_s;
  logic [1:0]            col_r,     col_s;
  logic [1:0]            row_idx_r, row_idx_s;
  logic [DB_WIDTH-1:0]   db_cnt_r,  db_cnt_s;
  logic [3:0]            cols_r,    cols_s;
  logic [3:0]            key_r,     key_s;
  logic                  valid_r,   valid_s;
  logic [15:0]           data_r,    data_s;
  logic [2:0]            hit_s;
  logic [3:0]            code_s;
  logic                  accept_s;

  assign rows_s      = rows_sync_r;
  assign o_cols      = cols_r;
  assign o_key       = key_r;
  assign o_key_valid = valid_r;
  assign o_data      = data_r;

  // Two-flop synchroniser for the asynchronous, pulled-up row inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_r <= 4'hF;
      rows_sync_r <= 4'hF;
    end else begin
      rows_meta_r <= i_rows;
      rows_sync_r <= rows_meta_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_SCAN;
      div_r     <= {SCAN_WIDTH{1'b0}};
      col_r     <= 2'd0;
      row_idx_r <= 2'd0;
      db_cnt_r  <= {DB_WIDTH{1'b0}};
      cols_r    <= 4'b1110;
      key_r     <= 4'h0;
      valid_r   <= 1'b0;
      data_r    <= 16'h0000;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      col_r     <= col_s;
      row_idx_r <= row_idx_s;
      db_cnt_r  <= db_cnt_s;
      cols_r    <= cols_s;
      key_r     <= key_s;
      valid_r   <= valid_s;
      data_r    <= data_s;
    end
  end

  // Next-state logic: scan, debounce press, wait for release, debounce release.
  always_comb begin
    state_s   = state_r;
    div_s     = {SCAN_WIDTH{1'b0}};
    col_s     = col_r;
    row_idx_s = row_idx_r;
    db_cnt_s  = db_cnt_r;
    accept_s  = 1'b0;
    hit_s     = single_low(rows_s);
    code_s    = key_code(row_idx_r, col_r);

    case (state_r)
      ST_SCAN: begin
        // Divider only runs here, so any return to SCAN restarts the dwell.
        div_s = div_r + SCAN_WIDTH'(1);
        if (div_r == DIV_LAST) begin
          if (hit_s[2]) begin
            state_s   = ST_DEBOUNCE;
            row_idx_s = hit_s[1:0];
            db_cnt_s  = {DB_WIDTH{1'b0}};
          end else begin
            // Idle or ghosted multi-press: move on to the next column.
            col_s = col_r + 2'd1;
          end
        end else begin
          col_s = col_r;
        end
      end
      ST_DEBOUNCE: begin
        if (rows_s == one_cold(row_idx_r)) begin
          if (db_cnt_r == DB_LAST) begin
            state_s  = ST_HELD;
            db_cnt_s = {DB_WIDTH{1'b0}};
            accept_s = 1'b1;
          end else begin
            db_cnt_s = db_cnt_r + DB_WIDTH'(1);
          end
        end else begin
          state_s  = ST_SCAN;
          db_cnt_s = {DB_WIDTH{1'b0}};
        end
      end
      ST_HELD: begin
        // No auto-repeat; other keys are ignored until everything is up.
        if (rows_s == 4'hF) begin
          state_s  = ST_RELEASE;
          db_cnt_s = {DB_WIDTH{1'b0}};
        end else begin
          state_s  = ST_HELD;
        end
      end
      ST_RELEASE: begin
        if (rows_s == 4'hF) begin
          if (db_cnt_r == DB_LAST) begin
            state_s  = ST_SCAN;
            col_s    = col_r + 2'd1;
            db_cnt_s = {DB_WIDTH{1'b0}};
          end else begin
            db_cnt_s = db_cnt_r + DB_WIDTH'(1);
          end
        end else begin
          db_cnt_s = {DB_WIDTH{1'b0}};
        end
      end
      default: begin
        state_s  = ST_SCAN;
        col_s    = 2'd0;
        db_cnt_s = {DB_WIDTH{1'b0}};
      end
    endcase
  end

  // Output next values: key/pulse on accept, history shift with clear priority.
  always_comb begin
    cols_s  = one_cold(col_s);
    key_s   = key_r;
    valid_s = 1'b0;
    data_s  = data_r;
    if (accept_s) begin
      key_s   = code_s;
      valid_s = 1'b1;
    end else begin
      key_s   = key_r;
    end
    if (i_clear) begin
      data_s = 16'h0000;
    end else if (accept_s) begin
      data_s = {data_r[11:0], code_s};
    end else begin
      data_s = data_r;
    end
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Testbench for hex_keypad_scanner: a keypad matrix model drives the rows from
// the scanned columns; a scoreboard of expected keys checks every output cycle.
module tb_hex_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  i_rows;
  logic        i_clear;
  logic [3:0]  o_cols;
  logic [3:0]  o_key;
  logic        o_key_valid;
  logic [15:0] o_data;

  logic [15:0] pressed;      // bit row*4+col = that key physically down
  logic [3:0]  kp_rows;
  logic [3:0]  exp_q[$];     // keys the bench expects to be accepted, in order
  logic [3:0]  model_key;
  logic [15:0] model_data;
  logic        clr_q;
  int          checks;
  int          errors;
  int          pulse_cnt;

  hex_keypad_scanner #(.SCAN_WIDTH(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rows      (i_rows),
    .i_clear     (i_clear),
    .o_cols      (o_cols),
    .o_key       (o_key),
    .o_key_valid (o_key_valid),
    .o_data      (o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row to its column when driven low.
  always_comb begin
    kp_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !o_cols[c]) kp_rows[r] = 1'b0;
  end
  assign i_rows = kp_rows;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endfunction

  // Matrix position of each hex code, from the keypad legend.
  function automatic int pos_of(input logic [3:0] code);
    case (code)
      4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
      4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
      4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
      4'h0: return 12;  4'hF: return 13;  4'hE: return 14;  default: return 15;
    endcase
  endfunction

  // Capture clear as the DUT sees it at the active edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_q <= 1'b0;
    else        clr_q <= i_clear;
  end

  // Per-cycle compare against the scoreboard model.
  always @(negedge clk) begin
    chk("cols_one_cold", 16'($countones(~o_cols)), 16'd1);
    if (!rst_n) begin
      model_key  = 4'h0;
      model_data = 16'h0000;
      chk("reset_valid", {15'd0, o_key_valid}, 16'd0);
    end else begin
      if (clr_q) model_data = 16'h0000;
      if (o_key_valid) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_pulse actual key=%h expected none at %0t", o_key, $time);
        end else begin
          model_key = exp_q.pop_front();
          if (!clr_q) model_data = {model_data[11:0], model_key};
        end
      end
    end
    chk("o_key", {12'd0, o_key}, {12'd0, model_key});
    chk("o_data", o_data, model_data);
  end

  task automatic tap(input logic [3:0] code, input int hold);
    int p;
    p = pos_of(code);
    exp_q.push_back(code);
    pressed[p] = 1'b1;
    repeat (hold) @(negedge clk);
    pressed[p] = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  // Wait for the column-3 dwell to begin (divider just restarted at 0).
  task automatic sync_to_col3();
    logic [3:0] prev;
    bit ok;
    ok = 1'b0;
    prev = o_cols;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (prev == 4'b1011 && o_cols == 4'b0111) begin
        ok = 1'b1;
        break;
      end
      prev = o_cols;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL col3_sync_timeout actual=no_transition expected=1011->0111");
    end
  endtask

  initial begin
    int p0;
    int changes;
    logic [3:0] prev;
    checks = 0; errors = 0; pulse_cnt = 0;
    model_key = 4'h0; model_data = 16'h0000;
    rst_n = 1'b0; i_clear = 1'b0; pressed = 16'h0000;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_cols", {12'd0, o_cols}, 16'h000E);
    chk("rst_key", {12'd0, o_key}, 16'h0000);
    chk("rst_data", o_data, 16'h0000);

    // Idle column rotation: 4 clocks per column starting at column 0.
    #2 rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      chk("idle_cols", {12'd0, o_cols}, {12'd0, ~(4'b0001 << ((k / 4) % 4))});
      if (k == 4)  chk("idle_cols_k4",  {12'd0, o_cols}, 16'h000D);
      if (k == 12) chk("idle_cols_k12", {12'd0, o_cols}, 16'h0007);
      @(negedge clk);
    end

    // Single key '6' held 100 cycles.
    p0 = pulse_cnt;
    tap(4'h6, 100);
    chk("k6_pulses", 16'(pulse_cnt - p0), 16'd1);
    chk("k6_key", {12'd0, o_key}, 16'h0006);
    chk("k6_data", o_data, 16'h0006);

    // History: 1,2,3,A then F drops the oldest nibble.
    p0 = pulse_cnt;
    tap(4'h1, 60); tap(4'h2, 60); tap(4'h3, 60); tap(4'hA, 60);
    chk("hist4_data", o_data, 16'h123A);
    tap(4'hF, 60);
    chk("hist5_data", o_data, 16'h23AF);
    chk("hist_pulses", 16'(pulse_cnt - p0), 16'd5);
    chk("hist_drained", 16'(exp_q.size()), 16'd0);

    // Bouncing press and bouncing release of key '4'.
    p0 = pulse_cnt;
    exp_q.push_back(4'h4);
    for (int t = 0; t < 8; t++) begin
      pressed[4] = (t % 2 == 0);
      repeat (3) @(negedge clk);
    end
    pressed[4] = 1'b1;
    repeat (60) @(negedge clk);
    for (int t = 0; t < 8; t++) begin
      pressed[4] = (t % 2 == 1);
      repeat (3) @(negedge clk);
    end
    pressed[4] = 1'b0;
    repeat (40) @(negedge clk);
    chk("bounce_pulses", 16'(pulse_cnt - p0), 16'd1);
    chk("bounce_key", {12'd0, o_key}, 16'h0004);
    chk("bounce_data", o_data, 16'h3AF4);

    // Ghost: rows 0 and 2 low in column 1 -> rejected, scanning continues.
    p0 = pulse_cnt;
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    changes = 0;
    prev = o_cols;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (o_cols != prev) changes++;
      prev = o_cols;
    end
    pressed[1] = 1'b0;
    pressed[9] = 1'b0;
    repeat (20) @(negedge clk);
    chk("ghost_col_steps", 16'(changes), 16'd16);
    chk("ghost_pulses", 16'(pulse_cnt - p0), 16'd0);

    // Clear coinciding with the accept of 'C' (row 2, column 3).
    // Col3 starts at edge E; rows_s sees it at E+2, tick at E+4, accept at E+12.
    p0 = pulse_cnt;
    sync_to_col3();
    exp_q.push_back(4'hC);
    pressed[11] = 1'b1;
    repeat (11) @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    chk("clr_accept_valid", {15'd0, o_key_valid}, 16'd1);
    chk("clr_accept_data", o_data, 16'h0000);
    repeat (30) @(negedge clk);
    pressed[11] = 1'b0;
    repeat (40) @(negedge clk);
    chk("clr_pulses", 16'(pulse_cnt - p0), 16'd1);
    chk("clr_key", {12'd0, o_key}, 16'h000C);
    chk("clr_data", o_data, 16'h0000);

    // Reset asserted mid-debounce: immediate column 0, no pulse afterwards.
    p0 = pulse_cnt;
    sync_to_col3();
    pressed[11] = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cols", {12'd0, o_cols}, 16'h000E);
    chk("midrst_valid", {15'd0, o_key_valid}, 16'd0);
    chk("midrst_key", {12'd0, o_key}, 16'h0000);
    pressed[11] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_pulses", 16'(pulse_cnt - p0), 16'd0);
    chk("midrst_data", o_data, 16'h0000);
    chk("final_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
